// File: rtl/muldiv_unit.sv
// Iterative RISC-V M-extension multiply/divide unit: one shift-add or restoring
// shift-subtract step per cycle, with single-cycle completion for special divides.
//
// state | meaning
// IDLE  | waiting for start; operands sampled on acceptance
// CALC  | one datapath step per cycle, count runs WIDTH-1 down to 0
// DONE  | done pulse, f holds the signed-corrected result
module muldiv_unit #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [2:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] f
);

   localparam int CW = $clog2(WIDTH);
   localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

   typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

   state_t           state;
   logic [CW-1:0]    count;
   logic [WIDTH-1:0] hi;
   logic [WIDTH-1:0] lo;
   logic [WIDTH-1:0] dvs;
   logic [2:0]       op_q;
   logic             neg_q;
   logic             neg_r;

   logic             a_sgn, b_sgn, a_neg, b_neg;
   logic [WIDTH-1:0] mag_a, mag_b;
   logic             div_zero, div_ovf;
   logic [WIDTH-1:0] special_f;
   logic [WIDTH:0]   shifted;
   logic [WIDTH:0]   sum;
   logic [WIDTH-1:0] step_hi, step_lo;
   logic [2*WIDTH-1:0] prod, prod_s;
   logic [WIDTH-1:0] quo, rmd, result;

   always_comb begin
      a_sgn = (op != 3'd3) && (op != 3'd5) && (op != 3'd7);
      b_sgn = (op == 3'd0) || (op == 3'd1) || (op == 3'd4) || (op == 3'd6);
      a_neg = a_sgn & a[WIDTH-1];
      b_neg = b_sgn & b[WIDTH-1];
      mag_a = a_neg ? -a : a;
      mag_b = b_neg ? -b : b;

      div_zero  = op[2] && (b == '0);
      div_ovf   = op[2] && !op[0] && (a == MIN_NEG) && (b == '1);
      special_f = '0;
      if (div_zero)
         special_f = op[1] ? a : '1;
      else if (div_ovf)
         special_f = op[1] ? '0 : a;

      // hi:lo is the product register (multiply) or remainder:dividend (divide)
      shifted = {hi, lo[WIDTH-1]};
      sum     = {1'b0, hi};
      step_hi = hi;
      step_lo = lo;
      if (op_q[2]) begin
         if (shifted >= {1'b0, dvs}) begin
            step_hi = shifted[WIDTH-1:0] - dvs;
            step_lo = {lo[WIDTH-2:0], 1'b1};
         end else begin
            step_hi = shifted[WIDTH-1:0];
            step_lo = {lo[WIDTH-2:0], 1'b0};
         end
      end else begin
         if (lo[0])
            sum = {1'b0, hi} + {1'b0, dvs};
         step_hi = sum[WIDTH:1];
         step_lo = {sum[0], lo[WIDTH-1:1]};
      end

      prod   = {step_hi, step_lo};
      prod_s = neg_q ? -prod : prod;
      quo    = neg_q ? -step_lo : step_lo;
      rmd    = neg_r ? -step_hi : step_hi;

      case (op_q)
         3'd0:                result = prod_s[WIDTH-1:0];
         3'd1, 3'd2, 3'd3:    result = prod_s[2*WIDTH-1:WIDTH];
         3'd4, 3'd5:          result = quo;
         default:             result = rmd;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         busy  <= 1'b0;
         done  <= 1'b0;
         f     <= '0;
         count <= '0;
         hi    <= '0;
         lo    <= '0;
         dvs   <= '0;
         op_q  <= '0;
         neg_q <= 1'b0;
         neg_r <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               done <= 1'b0;
               if (start) begin
                  op_q <= op;
                  busy <= 1'b1;
                  if (div_zero || div_ovf) begin
                     f     <= special_f;
                     done  <= 1'b1;
                     state <= DONE;
                  end else begin
                     hi    <= '0;
                     lo    <= op[2] ? mag_a : mag_b;
                     dvs   <= op[2] ? mag_b : mag_a;
                     neg_q <= a_neg ^ b_neg;
                     neg_r <= a_neg;
                     count <= CW'(WIDTH-1);
                     state <= CALC;
                  end
               end
            end
            CALC: begin
               hi <= step_hi;
               lo <= step_lo;
               if (count == '0) begin
                  f     <= result;
                  done  <= 1'b1;
                  state <= DONE;
               end else begin
                  count <= count - CW'(1);
               end
            end
            DONE: begin
               done  <= 1'b0;
               busy  <= 1'b0;
               state <= IDLE;
            end
            default: begin
               done  <= 1'b0;
               busy  <= 1'b0;
               state <= IDLE;
            end
         endcase
      end
   end

endmodule
